pipeline_hold_ctrl: RTL and testbench
=====================================

PIPELINE_HOLD_CTRL -- requirements
Module: pipeline_hold_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, SHALL set the number of RUN-state cycles of the multi-cycle divide (legal range 2..63).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-004 stall_req_if  in  1  instruction fetch not ready.
REQ-005 stall_req_id  in  1  load-use hazard detected in ID.
REQ-006 stall_req_mem  in  1  data memory not ready.
REQ-007 div_start  in  1  EX holds a DIV/DIVU; one-cycle request to launch the divider.
REQ-008 flush  in  1  branch/exception redirect; kill instructions in IF_ID and ID_EX.
REQ-009 hold  out  5  per pipeline register is_hold, bit0=PC, 1=IF_ID, 2=ID_EX, 3=EX_MEM, 4=MEM_WB; 1 = register keeps its value.
REQ-010 bubble  out  5  same bit map; 1 = register loads a NOP (all-zero control) at the next edge.
REQ-011 div_busy  out  1  divider running.
REQ-012 div_done  out  1  divide result valid for capture into EX_MEM (HI/LO) this cycle.

Function
REQ-013 Stall level k SHALL be the highest active source: MEM=3 (stall_req_mem), EX=2 (ex_stall), ID=1 (stall_req_id), IF=0 (stall_req_if); none = no stall.
REQ-014 With stall level k: hold[k:0]=1, bubble[k+1]=1, all other hold/bubble bits 0; hold and bubble SHALL be combinational in the same cycle as the request (zero latency).
REQ-015 hold[4] and bubble[0] SHALL always be 0 (MEM_WB never stalled, PC never bubbled).
REQ-016 Divide FSM states: IDLE, RUN, DONE; counter cnt is 6 bits.
REQ-017 IDLE: div_start=1 and flush=0 SHALL go to RUN and load cnt=DIV_CYCLES-1; ex_stall=1 already in that cycle.
REQ-018 RUN: ex_stall=1, div_busy=1; cnt SHALL decrement every cycle regardless of stall_req_mem; at cnt=0 go to DONE.
REQ-019 DONE: div_done=1, ex_stall=0, div_busy=1; SHALL return to IDLE on the first cycle with stall_req_mem=0 and SHALL stay in DONE while stall_req_mem=1.
REQ-020 div_start in RUN or DONE SHALL be ignored (no restart, no counter reload).
REQ-021 flush in RUN or DONE SHALL abort the divide: next state IDLE, div_done not asserted for that divide.
REQ-022 flush with stall_req_mem=0: bubble[1]=1 and bubble[2]=1 in that cycle, hold[1]=hold[2]=0; overrides ID/IF/EX stall bits for those registers; hold[0]=0.
REQ-023 flush with stall_req_mem=1: flush SHALL be latched into flush_pend and applied (REQ-022 behaviour) in the first cycle stall_req_mem=0; flush_pend clears then; flush repeated while pending SHALL not queue twice.
REQ-024 Where bubble[i]=1 and hold[i]=1 would both result, bubble SHALL win and hold[i] SHALL be 0.

Reset
REQ-025 While rst=0: FSM=IDLE, cnt=0, flush_pend=0, div_busy=0, div_done=0.
REQ-026 While rst=0, hold=5'b00000 and bubble=5'b00000 regardless of request inputs.
REQ-027 Reset asserted mid-divide SHALL discard the divide; first cycle after release FSM is IDLE.

Verification
REQ-028 stall_req_id=1 alone -> hold=5'b00011, bubble=5'b00100 same cycle; drop -> both 0.
REQ-029 stall_req_id=1 and stall_req_mem=1 -> hold=5'b01111, bubble=5'b10000.
REQ-030 DIV_CYCLES=32, div_start pulse at cycle 0 -> hold=5'b00111, bubble=5'b01000 cycles 0..32, div_done=1 at cycle 33 only, div_busy=0 from cycle 34.
REQ-031 div_done cycle with stall_req_mem=1 for 3 cycles -> div_done stays 1 for 4 cycles, IDLE after stall_req_mem falls.
REQ-032 flush at cycle 10 of a running divide -> bubble=5'b00110, div_busy=0 next cycle, no div_done pulse.
REQ-033 flush while stall_req_mem=1 for 2 cycles -> bubble[2:1]=0 during stall, bubble=5'b00110 in first cycle after; rst pulsed low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_hold_ctrl.sv
// pipeline_hold_ctrl: per-stage hold/bubble generation for a 5-stage pipeline with a multi-cycle divider
module pipeline_hold_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_req_if,
  input  logic       stall_req_id,
  input  logic       stall_req_mem,
  input  logic       div_start,
  input  logic       flush,
  output logic [4:0] hold,
  output logic [4:0] bubble,
  output logic       div_busy,
  output logic       div_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       flush_pend_q, flush_pend_d;
  logic       ex_stall, flush_eff;
  logic [3:0] stall_mask;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    case (state_q)
      IDLE: if (div_start && !flush) begin
        state_d  = RUN;
        cnt_d    = 6'(DIV_CYCLES - 1);
        ex_stall = 1'b1;
      end
      RUN: begin
        ex_stall = 1'b1;
        cnt_d    = cnt_q - 6'd1;
        state_d  = flush ? IDLE : (cnt_q == 6'd0) ? DONE : RUN;
      end
      DONE: state_d = (flush || !stall_req_mem) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // a flush seen under a MEM stall waits until MEM releases, and only once
  assign flush_eff    = (flush | flush_pend_q) & ~stall_req_mem;
  assign flush_pend_d = stall_req_mem & (flush | flush_pend_q);
  assign stall_mask   = stall_req_mem ? 4'b1111 :
                        ex_stall      ? 4'b0111 :
                        stall_req_id  ? 4'b0011 :
                        stall_req_if  ? 4'b0001 : 4'b0000;
  assign hold     = (!rst || flush_eff) ? 5'b00000 : {1'b0, stall_mask};
  assign bubble   = !rst ? 5'b00000 : flush_eff ? 5'b00110 :
                    {stall_mask, 1'b0} & ~{1'b0, stall_mask};
  assign div_busy = rst && (state_q != IDLE);
  assign div_done = rst && (state_q == DONE) && !flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// tb_pipeline_hold_ctrl: directed and random checks of hold/bubble/divider against a cycle-count model
module tb_pipeline_hold_ctrl;
  localparam int DIV = 32;
  logic       clk = 1'b0, rst = 1'b0;
  logic       s_if = 1'b0, s_id = 1'b0, s_mem = 1'b0, div_start = 1'b0, flush = 1'b0;
  logic [4:0] hold, bubble;
  logic       div_busy, div_done;
  int         checks = 0, errors = 0;
  int         run_left = 0;
  bit         done_f = 1'b0, pend = 1'b0;

  pipeline_hold_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst), .stall_req_if(s_if), .stall_req_id(s_id), .stall_req_mem(s_mem),
    .div_start(div_start), .flush(flush), .hold(hold), .bubble(bubble),
    .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // expected outputs from the stall-priority rules and the remaining divide length
  task automatic model_check(input string tag);
    int k;
    bit run, ex, fe;
    logic [4:0] eh, eb;
    run = run_left > 0;
    ex  = run || (!done_f && div_start && !flush);
    k   = s_mem ? 3 : ex ? 2 : s_id ? 1 : s_if ? 0 : -1;
    fe  = !s_mem && (flush || pend);
    eh  = (fe || k < 0) ? 5'd0 : 5'((1 << (k + 1)) - 1);
    eb  = fe ? 5'b00110 : (k < 0) ? 5'd0 : 5'(1 << (k + 1));
    chk({tag, ".hold"}, hold, eh);
    chk({tag, ".bubble"}, bubble, eb);
    chk({tag, ".busy"}, {4'd0, div_busy}, {4'd0, run || done_f});
    chk({tag, ".done"}, {4'd0, div_done}, {4'd0, done_f && !flush});
  endtask

  task automatic model_advance();
    if (run_left > 0) begin
      if (flush) run_left = 0;
      else begin
        run_left--;
        if (run_left == 0) done_f = 1'b1;
      end
    end else if (done_f) begin
      if (flush || !s_mem) done_f = 1'b0;
    end else if (div_start && !flush) run_left = DIV;
    pend = s_mem && (flush || pend);
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    int done_cnt;
    s_if = 1; s_id = 1; s_mem = 1; div_start = 1; flush = 1;
    #2;
    chk("rst.hold", hold, 5'b00000);
    chk("rst.bubble", bubble, 5'b00000);
    chk("rst.busy", {4'd0, div_busy}, 5'd0);
    chk("rst.done", {4'd0, div_done}, 5'd0);
    s_if = 0; s_id = 0; s_mem = 0; div_start = 0; flush = 0;
    @(posedge clk); #1 rst = 1;
    cyc("idle");
    s_id = 1; #1;
    chk("id.hold", hold, 5'b00011);
    chk("id.bubble", bubble, 5'b00100);
    cyc("id");
    s_mem = 1; #1;
    chk("idmem.hold", hold, 5'b01111);
    chk("idmem.bubble", bubble, 5'b10000);
    cyc("idmem");
    s_id = 0; s_mem = 0;
    cyc("drop");
    div_start = 1; #1;
    chk("div0.hold", hold, 5'b00111);
    chk("div0.bubble", bubble, 5'b01000);
    cyc("div");
    div_start = 0;
    done_cnt = 0;
    for (int i = 1; i < 40; i++) begin
      #1 if (div_done) done_cnt++;
      if (i == 33) chk("div33.done", {4'd0, div_done}, 5'd1);
      if (i == 34) chk("div34.busy", {4'd0, div_busy}, 5'd0);
      cyc("div");
    end
    chk("div.done_count", 5'(done_cnt), 5'd1);
    div_start = 1; cyc("dmem"); div_start = 0;
    repeat (32) cyc("dmem");
    s_mem = 1;
    repeat (3) cyc("dmem.hold");
    s_mem = 0;
    repeat (3) cyc("dmem.rel");
    div_start = 1; cyc("dfl"); div_start = 0;
    repeat (9) cyc("dfl");
    flush = 1; #1;
    chk("dfl.bubble", bubble, 5'b00110);
    cyc("dfl.flush");
    flush = 0;
    repeat (30) cyc("dfl.after");
    s_mem = 1; flush = 1; cyc("pend");
    flush = 0; cyc("pend");
    s_mem = 0; #1;
    chk("pend.bubble", bubble, 5'b00110);
    cyc("pend.apply");
    cyc("pend.clear");
    div_start = 1; cyc("rstrun"); div_start = 0;
    repeat (5) cyc("rstrun");
    s_id = 1; s_mem = 1;
    rst = 0; #1;
    chk("rstrun.hold", hold, 5'b00000);
    chk("rstrun.bubble", bubble, 5'b00000);
    chk("rstrun.busy", {4'd0, div_busy}, 5'd0);
    run_left = 0; done_f = 0; pend = 0;
    s_id = 0; s_mem = 0;
    @(posedge clk); #1 rst = 1;
    cyc("rstrun.idle");
    for (int i = 0; i < 3000; i++) begin
      s_if      = ($urandom % 4) == 0;
      s_id      = ($urandom % 5) == 0;
      s_mem     = ($urandom % 5) == 0;
      div_start = ($urandom % 8) == 0;
      flush     = ($urandom % 40) == 0;
      cyc("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
